gpio_mmio: RTL and testbench
============================

# gpio_mmio

Memory-mapped GPIO peripheral between the board pins and `pipeline_cpu`'s data-memory stage. Synchronizes and debounces the 8 slide switches, holds the 8-bit LED output register, and latches rising edges on debounced switches into a sticky, interrupt-capable status register. The CPU's load/store path reaches it through a single-cycle-request, registered-response bus.

## Interface
- `BASE_ADDR`, default 32'hFFFF_0000, word-aligned base of the 16-byte register window; only bits [31:4] are compared.
- `DEBOUNCE_CYCLES`, default 4, consecutive cycles a synchronized input must differ from the stable value before the stable value updates; legal range 2..65535.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `switches`  in  8  raw switch pins, asynchronous to `clk`.
- `leds`  out  8  LED drive, equal to the LED register.
- `addr`  in  32  byte address from the CPU memory stage.
- `wdata`  in  32  store data.
- `we`  in  1  store strobe, one cycle per access.
- `re`  in  1  load strobe, one cycle per access.
- `rdata`  out  32  registered load data.
- `rvalid`  out  1  high for exactly one cycle, the cycle after an accepted `re`.
- `irq`  out  1  level interrupt, `|(EDGE & IRQ_EN)`.

## Operation
- Select: `sel = (addr[31:4] == BASE_ADDR[31:4])`; register index is `addr[3:2]`; `addr[1:0]` is ignored.
- Register map (offset, access, contents):
  - 0x0 SW, RO: bits [7:0] debounced switch state, upper bits 0.
  - 0x4 LED, RW: bits [7:0] drive `leds`, upper write bits discarded, read back as 0.
  - 0x8 EDGE, W1C: bit i set on a 0->1 transition of debounced bit i.
  - 0xC IRQ_EN, RW: bits [7:0].
- Synchronizer: two flops per bit, `sync2` feeds the debouncer.
- Debouncer, per bit, with `stable` and a 16-bit `cnt`:
  - If `sync2 != stable` and `cnt == DEBOUNCE_CYCLES-1`: `stable <= sync2`, `cnt <= 0`.
  - If `sync2 != stable` otherwise: `cnt <= cnt+1`.
  - If `sync2 == stable`: `cnt <= 0`. Any glitch restarts the count.
- Edge detect: `rise = stable_next & ~stable`. `EDGE <= (EDGE & ~clr) | rise`, where `clr = wdata[7:0]` on a selected write to 0x8, else 0. If set and clear hit the same bit in the same cycle, set wins.
- Writes to SW: no effect. Writes with `sel=0`: ignored.
- Reads: `rdata <= sel ? reg[addr[3:2]] : 0` on `re`; otherwise `rdata` holds its value. `rvalid <= re`, regardless of `sel`.
- `we` and `re` high together: both performed. A read of a register being written that cycle returns the old value.

## Timing
- Reset values, all zero: both sync stages, `stable`, every `cnt`, LED, EDGE, IRQ_EN, `rdata`, `rvalid`, `irq`, `leds`.
- Reset assert takes effect immediately, mid-debounce or mid-access. Any pending `rvalid` is dropped.
- Pin-to-SW latency: a clean pin change is visible in `stable` after 2 + `DEBOUNCE_CYCLES` rising edges.
- EDGE bit sets on the same edge that `stable` rises. `irq` is combinational from registers, so it is high that same cycle if enabled.
- LED write: `leds` updates on the edge that samples `we`.
- Read latency: 1 cycle. Back-to-back reads on consecutive cycles are fully supported, with one `rvalid` per `re`.
- `irq` falls the cycle after the W1C write that clears the last enabled pending bit, unless a new rise hit that bit in that cycle.

## Test plan
- Reset: hold `reset=0` with `switches=8'hAA` -> all outputs 0. Release, wait 2+4 cycles -> SW reads 0x000000AA and EDGE reads 0x000000AA.
- Debounce: toggle bit 0 high for 3 cycles, then low -> SW bit 0 unchanged, EDGE unchanged. Hold it high for 4 cycles -> SW bit 0 = 1 exactly 6 edges after the pin change.
- LED: write 0xDEADBE5A to 0x4 -> `leds=8'h5A` next edge. Read 0x4 -> `rdata=0x0000005A` with `rvalid` one cycle after `re`.
- Interrupt: IRQ_EN=0x01, bit 0 rises -> `irq=1`. Write 0x01 to 0x8 -> `irq=0` next cycle. Repeat with a rise coinciding with the clear -> EDGE bit stays 1 and `irq` stays 1.
- Decode: write 0xFF to `BASE_ADDR+0x10` -> LEDs unchanged. Read it -> `rdata=0`, `rvalid=1`. Write to 0x0 -> SW unchanged.
- Async reset mid-count: assert `reset` during a debounce window and during a pending read -> counters and `rvalid` clear immediately, with no spurious EDGE after release.

Source files
------------

// File: rtl/gpio_mmio.sv
// GPIO peripheral: synchronized and debounced switches, LED register, sticky
// rising-edge status with interrupt enable, single-cycle request / registered read bus.
module gpio_mmio #(
   parameter logic [31:0] BASE_ADDR       = 32'hFFFF_0000,
   parameter int          DEBOUNCE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  switches,
   output logic [7:0]  leds,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        we,
   input  logic        re,
   output logic [31:0] rdata,
   output logic        rvalid,
   output logic        irq
);

   localparam logic [15:0] CNT_MAX = 16'(DEBOUNCE_CYCLES - 1);

   logic [7:0]       sync1, sync2;
   logic [7:0]       stable, stable_next;
   logic [7:0][15:0] cnt, cnt_next;
   logic [7:0]       led_r, edge_r, irq_en;
   logic [7:0]       rise, clr;
   logic             sel;
   logic [1:0]       idx;
   logic [31:0]      rd_mux;
   logic             unused_bits;

   assign sel         = (addr[31:4] == BASE_ADDR[31:4]);
   assign idx         = addr[3:2];
   assign unused_bits = ^{wdata[31:8], addr[1:0]};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= switches;
         sync2 <= sync1;
      end
   end

   // Any cycle where sync2 agrees with stable restarts the window.
   always_comb begin
      stable_next = stable;
      cnt_next    = '0;
      for (int i = 0; i < 8; i++) begin
         if (sync2[i] != stable[i]) begin
            if (cnt[i] == CNT_MAX) stable_next[i] = sync2[i];
            else                   cnt_next[i]    = cnt[i] + 16'd1;
         end
      end
   end

   assign rise = stable_next & ~stable;
   assign clr  = (sel && we && idx == 2'd2) ? wdata[7:0] : 8'h00;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stable <= '0;
         cnt    <= '0;
         edge_r <= '0;
      end else begin
         stable <= stable_next;
         cnt    <= cnt_next;
         edge_r <= (edge_r & ~clr) | rise;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         led_r  <= '0;
         irq_en <= '0;
      end else if (sel && we) begin
         if (idx == 2'd1) led_r  <= wdata[7:0];
         if (idx == 2'd3) irq_en <= wdata[7:0];
      end
   end

   always_comb begin
      rd_mux = '0;
      case (idx)
         2'd0:    rd_mux = {24'h0, stable};
         2'd1:    rd_mux = {24'h0, led_r};
         2'd2:    rd_mux = {24'h0, edge_r};
         default: rd_mux = {24'h0, irq_en};
      endcase
   end

   // Read mux sees pre-edge register values, so a same-cycle write reads old data.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdata  <= '0;
         rvalid <= 1'b0;
      end else begin
         rvalid <= re;
         if (re) rdata <= sel ? rd_mux : 32'h0;
      end
   end

   assign leds = led_r;
   assign irq  = |(edge_r & irq_en);

endmodule

// File: tb/tb_gpio_mmio.sv
// Self-checking bench for gpio_mmio: read data is checked through an expected-value
// queue drained by a monitor; pins, LEDs and irq are checked inline by each test task.
module tb_gpio_mmio;

   localparam logic [31:0] BASE = 32'hFFFF_0000;

   logic        clk, reset;
   logic [7:0]  switches, leds;
   logic [31:0] addr, wdata, rdata;
   logic        we, re, rvalid, irq;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];

   gpio_mmio #(.BASE_ADDR(BASE), .DEBOUNCE_CYCLES(4)) dut (
      .clk(clk), .reset(reset), .switches(switches), .leds(leds),
      .addr(addr), .wdata(wdata), .we(we), .re(re),
      .rdata(rdata), .rvalid(rvalid), .irq(irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: rvalid must mirror the previous cycle's re; each rvalid pops one expectation.
   always begin
      logic re_s, rst_s;
      logic [31:0] e;
      @(posedge clk);
      re_s  = re;
      rst_s = reset;
      #1;
      if (reset && rst_s) begin
         checks++;
         if (rvalid !== re_s) begin
            errors++;
            $display("FAIL rvalid_timing: got %b want %b at %0t", rvalid, re_s, $time);
         end
         if (rvalid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL rdata_unexpected: got %h with no read pending", rdata);
            end else begin
               e = exp_q.pop_front();
               if (rdata !== e) begin
                  errors++;
                  $display("FAIL rdata: got %h want %h at %0t", rdata, e, $time);
               end
            end
         end
      end
   end

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      addr = a; wdata = d; we = 1'b1;
      @(negedge clk);
      we = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] a, input logic [31:0] e);
      addr = a; re = 1'b1;
      exp_q.push_back(e);
      @(negedge clk);
      re = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; switches = 8'hAA;
      repeat (3) @(negedge clk);
      checks += 4;
      if (leds !== 8'h00)  begin errors++; $display("FAIL reset_leds: got %h want 00", leds); end
      if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata); end
      if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b want 0", rvalid); end
      if (irq !== 1'b0)    begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
      reset = 1'b1;
      repeat (6) @(negedge clk);
      bus_read(BASE + 32'h0, 32'h0000_00AA);
      bus_read(BASE + 32'h8, 32'h0000_00AA);
   endtask

   task automatic test_debounce();
      bus_write(BASE + 32'hC, 32'h0000_0001);
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL irq_idle: got %b want 0", irq); end
      switches = 8'hAB;
      repeat (3) @(negedge clk);
      switches = 8'hAA;
      repeat (8) @(negedge clk);
      bus_read(BASE + 32'h0, 32'h0000_00AA);
      bus_read(BASE + 32'h8, 32'h0000_00AA);
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL glitch_irq: got %b want 0", irq); end
      switches = 8'hAB;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         checks++;
         if (irq !== (k == 6)) begin
            errors++;
            $display("FAIL debounce_latency: edge %0d irq got %b want %b", k, irq, (k == 6));
         end
      end
      bus_read(BASE + 32'h0, 32'h0000_00AB);
      bus_read(BASE + 32'h8, 32'h0000_00AB);
   endtask

   task automatic test_led();
      bus_write(BASE + 32'h4, 32'hDEAD_BE5A);
      checks++;
      if (leds !== 8'h5A) begin errors++; $display("FAIL led_write: got %h want 5a", leds); end
      bus_read(BASE + 32'h4, 32'h0000_005A);
   endtask

   task automatic test_irq();
      checks++;
      if (irq !== 1'b1) begin errors++; $display("FAIL irq_set: got %b want 1", irq); end
      bus_write(BASE + 32'h8, 32'h0000_0001);
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b want 0", irq); end
      switches = 8'hAA;
      repeat (8) @(negedge clk);
      switches = 8'hAB;
      repeat (5) @(negedge clk);
      bus_write(BASE + 32'h8, 32'h0000_0001);
      checks++;
      if (irq !== 1'b1) begin errors++; $display("FAIL irq_set_wins: got %b want 1", irq); end
      bus_read(BASE + 32'h8, 32'h0000_00AB);
      bus_write(BASE + 32'h8, 32'h0000_0001);
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear2: got %b want 0", irq); end
   endtask

   task automatic test_decode();
      bus_write(BASE + 32'h10, 32'h0000_00FF);
      checks++;
      if (leds !== 8'h5A) begin errors++; $display("FAIL decode_led: got %h want 5a", leds); end
      bus_read(BASE + 32'h10, 32'h0);
      bus_write(BASE + 32'h0, 32'h0000_00FF);
      bus_read(BASE + 32'h0, 32'h0000_00AB);
   endtask

   task automatic test_back_to_back();
      logic [31:0] a_l[4];
      logic [31:0] e_l[4];
      addr = BASE + 32'h4; wdata = 32'h0000_0033; we = 1'b1; re = 1'b1;
      exp_q.push_back(32'h0000_005A);
      @(negedge clk);
      we = 1'b0; re = 1'b0;
      checks++;
      if (leds !== 8'h33) begin errors++; $display("FAIL rw_same_cycle_led: got %h want 33", leds); end
      a_l = '{BASE + 32'h0, BASE + 32'h4, BASE + 32'h8, BASE + 32'hC};
      e_l = '{32'hAB, 32'h33, 32'hAA, 32'h01};
      for (int i = 0; i < 4; i++) begin
         addr = a_l[i]; re = 1'b1;
         exp_q.push_back(e_l[i]);
         @(negedge clk);
      end
      re = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_async_reset();
      switches = 8'h00;
      repeat (3) @(negedge clk);
      addr = BASE + 32'h4; re = 1'b1;
      exp_q.push_back(32'h0000_0033);
      @(posedge clk);
      #2 reset = 1'b0; re = 1'b0;
      #1;
      checks += 3;
      if (rvalid !== 1'b0) begin errors++; $display("FAIL async_rvalid: got %b want 0", rvalid); end
      if (leds !== 8'h00)  begin errors++; $display("FAIL async_leds: got %h want 00", leds); end
      if (rdata !== 32'h0) begin errors++; $display("FAIL async_rdata: got %h want 0", rdata); end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (10) @(negedge clk);
      bus_read(BASE + 32'h8, 32'h0);
      bus_read(BASE + 32'h0, 32'h0);
      // Restart a debounce window, reset in the middle, and expect a full-length window after.
      switches = 8'h01;
      repeat (4) @(negedge clk);
      #2 reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      bus_write(BASE + 32'hC, 32'h0000_0001);
      for (int k = 2; k <= 6; k++) begin
         @(negedge clk);
         checks++;
         if (irq !== (k == 6)) begin
            errors++;
            $display("FAIL async_window: edge %0d irq got %b want %b", k, irq, (k == 6));
         end
      end
   endtask

   initial begin
      reset = 1'b0; switches = 8'h00; addr = '0; wdata = '0; we = 1'b0; re = 1'b0;
      @(negedge clk);
      test_reset();
      test_debounce();
      test_led();
      test_irq();
      test_decode();
      test_back_to_back();
      test_async_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL reads_pending: got %0d outstanding want 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
